orclr_drain: RTL and testbench

Autonomous Wishbone master that services a 32-bit OR-clear event register, where hardware sets bits and a software write of 1 clears them. It polls the register, drains every set bit as an indexed event on a valid/ready stream, lowest index first, then clears exactly the dispatched bits with one write-1-to-clear access. It sits between the OR-clear register's Wishbone slave and an event consumer such as an interrupt mux or sequencer, so no CPU is needed to acknowledge events.

---
 rtl/orclr_drain_pkg.sv | 22 ++
 rtl/lsb_find.sv | 24 ++
 rtl/orclr_drain.sv | 162 ++++++++++++++++
 tb/tb_orclr_drain.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/orclr_drain_pkg.sv
// Shared types and widths for the OR-clear event drain master.
package orclr_drain_pkg;

  localparam int DATA_W = 32;
  localparam int ID_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    POLL,
    DISPATCH,
    WR_REQ,
    WR_WAIT
  } drain_state_t;

  // True in every state that holds the Wishbone cycle open.
  function automatic logic is_bus_state(input drain_state_t s);
    return (s == RD_REQ) || (s == RD_WAIT) || (s == WR_REQ) || (s == WR_WAIT);
  endfunction

endpackage

// File: rtl/lsb_find.sv
// Combinational lowest-set-bit encoder: index of the lowest 1 plus a found flag.
module lsb_find
  import orclr_drain_pkg::*;
(
  input  logic [DATA_W-1:0] vec,
  output logic [ID_W-1:0]   idx,
  output logic              found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a bit
    // pattern that never matches would leave idx/found holding and infer a latch.
    idx   = '0;
    found = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = ID_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/orclr_drain.sv
// Autonomous Wishbone master that polls an OR-clear event register, streams
// each set bit as an event (lowest index first) and then clears exactly the
// dispatched bits with a single write-1-to-clear access.
module orclr_drain
  import orclr_drain_pkg::*;
#(
  parameter logic [DATA_W-1:0] REG_ADR  = '0,
  parameter int                POLL_DIV = 16,
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [DATA_W-1:0] wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_stall_i,
  output logic              evt_valid_o,
  output logic [ID_W-1:0]   evt_id_o,
  input  logic              evt_ready_i,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  localparam int PD_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  drain_state_t      state, next_state;
  logic [DATA_W-1:0] pend, mask;
  logic [PD_W-1:0]   poll_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              err_flag;

  logic [ID_W-1:0]   low_idx;
  logic              low_found;
  logic [DATA_W-1:0] low_bit;
  logic              bus_open;
  logic              bus_fail;
  logic              bus_done;
  logic              handshake;
  logic              poll_end;
  logic              last_event;

  lsb_find u_lsb_find (
    .vec   (pend),
    .idx   (low_idx),
    .found (low_found)
  );

  // Decode of bus completion, failure, event handshake and poll expiry.
  always_comb begin
    bus_open   = is_bus_state(state);
    bus_fail   = bus_open && (wb_err_i || (!wb_ack_i && (to_cnt == TO_W'(TIMEOUT))));
    bus_done   = bus_open && wb_ack_i && !wb_err_i;
    handshake  = (state == DISPATCH) && low_found && evt_ready_i;
    low_bit    = DATA_W'(1) << low_idx;
    last_event = handshake && ((pend & ~low_bit) == '0);
    poll_end   = (state == POLL) && (poll_cnt == PD_W'(POLL_DIV - 1));
  end

  // State register; asynchronous reset returns to IDLE and drops cyc at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (enable_i) next_state = RD_REQ;
      RD_REQ: begin
        if (bus_fail)         next_state = POLL;
        else if (wb_ack_i)    next_state = (wb_dat_i == '0) ? POLL : DISPATCH;
        else if (!wb_stall_i) next_state = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus_fail)         next_state = POLL;
        else if (wb_ack_i)    next_state = (wb_dat_i == '0) ? POLL : DISPATCH;
      end
      POLL:     if (poll_end) next_state = enable_i ? RD_REQ : IDLE;
      DISPATCH: if (last_event || !low_found) next_state = WR_REQ;
      WR_REQ: begin
        if (bus_fail)         next_state = POLL;
        else if (wb_ack_i)    next_state = RD_REQ;
        else if (!wb_stall_i) next_state = WR_WAIT;
      end
      WR_WAIT: begin
        if (bus_fail)         next_state = POLL;
        else if (wb_ack_i)    next_state = RD_REQ;
      end
      default:                next_state = IDLE;
    endcase
  end

  // Snapshot/mask bookkeeping, poll and timeout counters, sticky error flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend     <= '0;
      mask     <= '0;
      poll_cnt <= '0;
      to_cnt   <= '0;
      err_flag <= 1'b0;
    end else begin
      if (bus_fail) begin
        // A failed write leaves its bits set in the register; they come back
        // on the next read, so the local copy is simply dropped.
        pend <= '0;
        mask <= '0;
      end else if (bus_done && !wb_we_o && (wb_dat_i != '0)) begin
        pend <= wb_dat_i;
        mask <= '0;
      end else if (handshake) begin
        pend <= pend & ~low_bit;
        mask <= mask | low_bit;
      end

      poll_cnt <= ((state == POLL) && !poll_end) ? poll_cnt + 1'b1 : '0;

      // Restart on every completion so back-to-back write/read each get a full budget.
      to_cnt <= (bus_open && !wb_ack_i && !bus_fail) ? to_cnt + 1'b1 : '0;

      if (bus_fail)       err_flag <= 1'b1;
      else if (err_clr_i) err_flag <= 1'b0;
    end
  end

  // Output decode from the current state.
  always_comb begin
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    evt_valid_o = 1'b0;
    case (state)
      RD_REQ:   begin wb_cyc_o = 1'b1; wb_stb_o = 1'b1; end
      RD_WAIT:  begin wb_cyc_o = 1'b1; end
      WR_REQ:   begin wb_cyc_o = 1'b1; wb_stb_o = 1'b1; wb_we_o = 1'b1; end
      WR_WAIT:  begin wb_cyc_o = 1'b1; wb_we_o = 1'b1; end
      DISPATCH: evt_valid_o = low_found;
      default:  ;
    endcase
    evt_id_o = evt_valid_o ? low_idx : '0;
    wb_dat_o = wb_we_o ? mask : '0;
    wb_adr_o = REG_ADR;
    wb_sel_o = 4'hF;
    busy_o   = (state != IDLE);
    err_o    = err_flag;
  end

endmodule

// File: tb/tb_orclr_drain.sv
// Directed bench for orclr_drain with an OR-clear register slave model and
// event/write-mask scoreboards.
module tb_orclr_drain;

  localparam logic [31:0] REG_ADR  = 32'h0000_0040;
  localparam int          POLL_DIV = 16;
  localparam int          TIMEOUT  = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_out, wb_dat_in;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err, wb_stall;
  logic        evt_valid, evt_ready;
  logic [4:0]  evt_id;
  logic        busy, err, err_clr;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int rd_acc  = 0;

  int          stall_n = 0;
  int          wait_n  = 0;
  bit          hang_wr = 1'b0;
  logic [31:0] reg_q   = 32'h0;
  logic [31:0] hw_set  = 32'h0;
  int          scnt = 0;
  int          wcnt = 0;

  int          exp_id_q[$];
  logic [31:0] exp_wr_q[$];

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [4:0]  prev_id    = '0;

  always #5 clk = ~clk;

  orclr_drain #(
    .REG_ADR  (REG_ADR),
    .POLL_DIV (POLL_DIV),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .enable_i    (enable),
    .wb_cyc_o    (wb_cyc),
    .wb_stb_o    (wb_stb),
    .wb_we_o     (wb_we),
    .wb_adr_o    (wb_adr),
    .wb_sel_o    (wb_sel),
    .wb_dat_o    (wb_dat_out),
    .wb_dat_i    (wb_dat_in),
    .wb_ack_i    (wb_ack),
    .wb_err_i    (wb_err),
    .wb_stall_i  (wb_stall),
    .evt_valid_o (evt_valid),
    .evt_id_o    (evt_id),
    .evt_ready_i (evt_ready),
    .busy_o      (busy),
    .err_o       (err),
    .err_clr_i   (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave responses: stall for stall_n cycles, then ack in the stb cycle
  // (wait_n=0) or wait_n cycles after the request is accepted.
  assign wb_dat_in = reg_q;
  assign wb_err    = 1'b0;
  always_comb begin
    wb_stall = wb_stb && (scnt < stall_n);
    wb_ack   = 1'b0;
    if (wb_cyc && !(wb_we && hang_wr)) begin
      if (wait_n == 0) wb_ack = wb_stb && !wb_stall;
      else             wb_ack = !wb_stb && (wcnt == wait_n - 1);
    end
  end

  // OR-clear register and slave counters.
  always @(posedge clk) begin
    reg_q   <= (reg_q & ~((wb_cyc && wb_we && wb_ack) ? wb_dat_out : 32'h0)) | hw_set;
    cyc_cnt <= cyc_cnt + 1;
    if (!wb_cyc || wb_ack) begin
      scnt <= 0;
      wcnt <= 0;
    end else begin
      if (wb_stb && wb_stall) scnt <= scnt + 1;
      if (!wb_stb)            wcnt <= wcnt + 1;
    end
  end

  // Scoreboard: pop expected event ids and write masks as the DUT produces them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid && evt_ready) begin
        if (exp_id_q.size() == 0) check("evt_unexpected", {27'd0, evt_id}, 32'hFFFF_FFFF);
        else                      check("evt_id", {27'd0, evt_id}, exp_id_q.pop_front());
      end
      if (wb_cyc && wb_we && wb_ack) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", wb_dat_out, 32'hDEAD_0000);
        else                      check("wr_mask", wb_dat_out, exp_wr_q.pop_front());
      end
      if (prev_valid && !prev_ready)
        check("evt_hold", {26'd0, evt_valid, evt_id}, {26'd0, 1'b1, prev_id});
      if (wb_cyc && wb_stb && !wb_stall && !wb_we) rd_acc <= rd_acc + 1;
      prev_valid <= evt_valid;
      prev_ready <= evt_ready;
      prev_id    <= evt_id;
    end else begin
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
    end
  end

  function automatic bit cond_met(input int which);
    case (which)
      0:       return wb_stb && !wb_we;
      1:       return wb_stb && wb_we;
      2:       return evt_valid;
      3:       return err;
      4:       return !wb_cyc && busy && !evt_valid;
      default: return (exp_id_q.size() == 0) && (exp_wr_q.size() == 0);
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cond_met(which)) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check(tag, 32'd0, 32'd1);
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hw(input logic [31:0] bits);
    drive_edge();
    hw_set = bits;
    drive_edge();
    hw_set = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, n, acc0;
    bit set5;
    rst_n = 1'b0; enable = 1'b0; evt_ready = 1'b1; err_clr = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ctrl", {27'd0, wb_cyc, wb_stb, wb_we, evt_valid, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_adr", wb_adr, REG_ADR);
    check("rst_sel", {28'd0, wb_sel}, 32'hF);
    check("rst_dat_id", wb_dat_out | {27'd0, evt_id}, 32'd0);
    drive_edge();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_enable", {30'd0, busy, wb_cyc}, 32'd0);

    // Empty register: enable latency and poll spacing.
    drive_edge();
    enable = 1'b1;
    @(negedge clk);
    check("en_same_cycle", {31'd0, wb_stb}, 32'd0);
    @(negedge clk);
    check("en_next_cycle", {29'd0, wb_cyc, wb_stb, wb_we}, 32'b110);
    c0 = cyc_cnt;
    wait_for(0, 40, "tmo_poll1");
    c1 = cyc_cnt;
    check("poll_spacing1", c1 - c0, POLL_DIV + 1);
    wait_for(0, 40, "tmo_poll2");
    check("poll_spacing2", cyc_cnt - c1, POLL_DIV + 1);
    check("empty_err", {31'd0, err}, 32'd0);

    // Three events back to back, one clear write, immediate re-read.
    wait_for(4, 40, "tmo_poll_a");
    exp_id_q.push_back(1); exp_id_q.push_back(4); exp_id_q.push_back(31);
    exp_wr_q.push_back(32'h8000_0012);
    pulse_hw(32'h8000_0012);
    wait_for(2, 40, "tmo_evt_a");
    @(negedge clk);
    check("evt_b2b_2", {31'd0, evt_valid}, 32'd1);
    @(negedge clk);
    check("evt_b2b_3", {31'd0, evt_valid}, 32'd1);
    @(negedge clk);
    check("wr_after_last", {30'd0, wb_stb, wb_we}, 32'b11);
    check("wr_data", wb_dat_out, 32'h8000_0012);
    @(negedge clk);
    check("reread", {30'd0, wb_stb, wb_we}, 32'b10);
    check("reread_data", wb_dat_in, 32'd0);
    @(negedge clk);
    check("poll_after_clear", {29'd0, busy, wb_cyc, evt_valid}, 32'b100);

    // Throttled consumer; hardware sets bit 5 during dispatch.
    wait_for(4, 40, "tmo_poll_b");
    evt_ready = 1'b0;
    exp_id_q.push_back(0); exp_id_q.push_back(1); exp_wr_q.push_back(32'h3);
    exp_id_q.push_back(5); exp_wr_q.push_back(32'h20);
    pulse_hw(32'h3);
    set5 = 1'b0;
    for (int i = 0; i < 120; i++) begin
      drive_edge();
      evt_ready = (i % 3 == 2);
      hw_set = 32'h0;
      if (!set5 && evt_valid) begin
        hw_set = 32'h20;
        set5 = 1'b1;
      end
      if (set5 && exp_id_q.size() == 0 && exp_wr_q.size() == 0) break;
    end
    hw_set = 32'h0;
    evt_ready = 1'b1;
    check("throttle_drained", exp_id_q.size() + exp_wr_q.size(), 32'd0);

    // Slave stalls until the ack cycle: one request, no duplicate.
    wait_for(4, 40, "tmo_poll_c");
    stall_n = 3;
    acc0 = rd_acc;
    exp_id_q.push_back(4); exp_wr_q.push_back(32'h10);
    pulse_hw(32'h10);
    wait_for(0, 40, "tmo_stall_rd");
    n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!wb_stb) break;
      n++;
    end
    check("stall_stb_len", n, 32'd4);
    check("stall_to_dispatch", {30'd0, evt_valid, wb_cyc}, 32'b10);
    check("stall_single_req", rd_acc - acc0, 32'd1);
    wait_for(5, 80, "tmo_stall_drain");
    stall_n = 0;

    // Write never acked: timeout, redispatch, sticky error then clear.
    wait_for(4, 40, "tmo_poll_d");
    hang_wr = 1'b1;
    exp_id_q.push_back(1); exp_id_q.push_back(4);
    exp_id_q.push_back(1); exp_id_q.push_back(4);
    exp_wr_q.push_back(32'h12);
    pulse_hw(32'h12);
    wait_for(1, 60, "tmo_hang_wr");
    c0 = cyc_cnt;
    check("hang_err_before", {31'd0, err}, 32'd0);
    wait_for(3, 300, "tmo_err");
    check("timeout_cycles", cyc_cnt - c0, TIMEOUT + 1);
    check("timeout_cyc_drop", {30'd0, wb_cyc, err}, 32'b01);
    drive_edge();
    hang_wr = 1'b0;
    wait_for(5, 200, "tmo_redispatch");
    check("err_sticky", {31'd0, err}, 32'd1);
    drive_edge();
    err_clr = 1'b1;
    drive_edge();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared", {31'd0, err}, 32'd0);

    // Asynchronous reset in WR_WAIT.
    wait_for(4, 40, "tmo_poll_e");
    wait_n = 2;
    exp_id_q.push_back(0);
    pulse_hw(32'h1);
    wait_for(1, 60, "tmo_wr_req");
    @(negedge clk);
    check("in_wr_wait", {29'd0, wb_cyc, wb_stb, wb_we}, 32'b101);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {29'd0, wb_cyc, evt_valid, busy}, 32'd0);
    enable = 1'b0;
    drive_edge();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {29'd0, busy, wb_cyc, err}, 32'd0);
    check("final_queues", exp_id_q.size() + exp_wr_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
